arp_tx_engine: RTL and testbench

Parametrised ARP transmit engine that serialises ARP replies and gratuitous ARP announcements onto a multi-byte MAC stream with per-beat flow control. It sits between the ARP parser's request FIFO and the Ethernet MAC transmit port. Unlike the byte-serial sender, it supports a configurable beat width, byte-enable/last framing, a guaranteed inter-frame gap and locally triggered announcements.

---
 rtl/arp_tx_engine.sv | 199 +++++++++++++++++++
 tb/tb_arp_tx_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_tx_engine.sv
// arp_tx_engine: serialises ARP replies and gratuitous ARP announcements onto a
// BYTES-wide MAC beat stream with byte-enable/last framing and a fixed inter-frame gap.
//
// Optional feature macro: ARP_TX_PAD_EN. When defined, frames are padded with zero bytes to
// the 60-byte Ethernet minimum; when undefined, frames are 42 bytes and no pad logic exists.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   hw_addr_i, ip_addr_i local MAC / IPv4 address, latched when a frame is accepted
//   arp_req_pkt_i        parsed ARP request; arp_req_pkt_valid_i / arp_req_pkt_ack_o pop it
//   garp_req_i           level request for a gratuitous ARP; garp_ack_o strobes on accept
//   mac_data_o           beat data, lane 0 = earliest byte on the wire
//   mac_keep_o           per-lane byte enable, contiguous from lane 0
//   mac_last_o           final beat of a frame
//   mac_valid_o          beat valid; mac_ack_i accepts it
//   busy_o               engine not idle
//   tx_cnt_o             completed frame count, wraps

package arp_tx_pkg;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [15:0] hw_type;
    logic [15:0] proto_type;
    logic [7:0]  hw_len;
    logic [7:0]  proto_len;
    logic [15:0] opcode;
    logic [47:0] sender_mac;
    logic [31:0] sender_ip;
    logic [47:0] target_mac;
    logic [31:0] target_ip;
  } ether_arp_frame_t;
endpackage

module arp_tx_engine
  import arp_tx_pkg::*;
#(
  parameter int unsigned BYTES      = 1,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [47:0]          hw_addr_i,
  input  logic [31:0]          ip_addr_i,
  input  ether_arp_frame_t     arp_req_pkt_i,
  input  logic                 arp_req_pkt_valid_i,
  output logic                 arp_req_pkt_ack_o,
  input  logic                 garp_req_i,
  output logic                 garp_ack_o,
  output logic [8*BYTES-1:0]   mac_data_o,
  output logic [BYTES-1:0]     mac_keep_o,
  output logic                 mac_last_o,
  output logic                 mac_valid_o,
  input  logic                 mac_ack_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     tx_cnt_o
);

`ifdef ARP_TX_PAD_EN
  localparam int unsigned FrameLen = 60;
`else
  localparam int unsigned FrameLen = 42;
`endif

  localparam int unsigned ArpBits  = $bits(ether_arp_frame_t);
  localparam int unsigned NumBeats = (FrameLen + BYTES - 1) / BYTES;
  localparam int unsigned BeatW    = 8 * BYTES;
  // Buffer is a whole number of beats; bytes past FrameLen stay zero.
  localparam int unsigned BufW     = NumBeats * BeatW;
  localparam int unsigned LastLen  = FrameLen - (NumBeats - 1) * BYTES;
  localparam logic [BYTES-1:0] LastKeep = BYTES'((64'd1 << LastLen) - 64'd1);

  localparam int unsigned BeatCntW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(NumBeats - 1);

  localparam int unsigned GapMax = (IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1;
  localparam int unsigned GapW   = (GapMax > 0) ? $clog2(GapMax + 1) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GapMax);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e              state_q, state_d;
  logic [BeatCntW-1:0] beat_q, beat_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [BufW-1:0]     buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  ether_arp_frame_t reply_frame, garp_frame;

  // Fields of the request that the reply never echoes.
  logic unused_req_fields;
  assign unused_req_fields = ^{arp_req_pkt_i.dst_mac, arp_req_pkt_i.eth_type,
                               arp_req_pkt_i.hw_type, arp_req_pkt_i.proto_type,
                               arp_req_pkt_i.hw_len, arp_req_pkt_i.proto_len,
                               arp_req_pkt_i.opcode, arp_req_pkt_i.target_mac,
                               arp_req_pkt_i.target_ip};

  always_comb begin
    reply_frame            = '0;
    reply_frame.dst_mac    = arp_req_pkt_i.src_mac;
    reply_frame.src_mac    = hw_addr_i;
    reply_frame.eth_type   = 16'h0806;
    reply_frame.hw_type    = 16'h0001;
    reply_frame.proto_type = 16'h0800;
    reply_frame.hw_len     = 8'd6;
    reply_frame.proto_len  = 8'd4;
    reply_frame.opcode     = 16'h0002;
    reply_frame.sender_mac = hw_addr_i;
    reply_frame.sender_ip  = ip_addr_i;
    reply_frame.target_mac = arp_req_pkt_i.sender_mac;
    reply_frame.target_ip  = arp_req_pkt_i.sender_ip;

    garp_frame            = reply_frame;
    garp_frame.dst_mac    = 48'hFFFF_FFFF_FFFF;
    garp_frame.opcode     = 16'h0001;
    garp_frame.target_mac = 48'h0;
    garp_frame.target_ip  = ip_addr_i;
  end

  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    gap_d             = gap_q;
    buf_d             = buf_q;
    cnt_d             = cnt_q;
    arp_req_pkt_ack_o = 1'b0;
    garp_ack_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Reply has priority; a pending announcement simply waits.
        if (arp_req_pkt_valid_i) begin
          arp_req_pkt_ack_o = 1'b1;
          buf_d             = BufW'(reply_frame) << (BufW - ArpBits);
          beat_d            = '0;
          state_d           = StSend;
        end else if (garp_req_i) begin
          garp_ack_o = 1'b1;
          buf_d      = BufW'(garp_frame) << (BufW - ArpBits);
          beat_d     = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (mac_ack_i) begin
          buf_d = buf_q << BeatW;
          if (beat_q == LastBeat) begin
            cnt_d   = cnt_q + CNT_W'(1);
            gap_d   = '0;
            state_d = (IFG_CYCLES == 0) ? StIdle : StGap;
          end else begin
            beat_d = beat_q + BeatCntW'(1);
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      gap_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Top byte of the buffer is the next byte on the wire and goes to lane 0.
  always_comb begin
    mac_data_o = '0;
    for (int i = 0; i < BYTES; i++) begin
      mac_data_o[8*i +: 8] = buf_q[BufW-1-8*i -: 8];
    end
  end

  assign mac_valid_o = (state_q == StSend);
  assign mac_last_o  = mac_valid_o && (beat_q == LastBeat);
  assign mac_keep_o  = !mac_valid_o ? '0 : (mac_last_o ? LastKeep : {BYTES{1'b1}});
  assign busy_o      = (state_q != StIdle);
  assign tx_cnt_o    = cnt_q;

endmodule

// File: tb/tb_arp_tx_engine.sv
// Scoreboard bench for arp_tx_engine (BYTES=4, IFG_CYCLES=12, CNT_W=2).
module tb_arp_tx_engine;
  import arp_tx_pkg::*;

  localparam int B   = 4;
  localparam int IFG = 12;
  localparam int CW  = 2;
`ifdef ARP_TX_PAD_EN
  localparam int FL = 60;
`else
  localparam int FL = 42;
`endif
  localparam int NB = (FL + B - 1) / B;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [47:0]      hw_addr = '0;
  logic [31:0]      ip_addr = '0;
  ether_arp_frame_t req_pkt = '0;
  logic             req_valid = 1'b0;
  logic             req_ack;
  logic             garp_req = 1'b0;
  logic             garp_ack;
  logic [8*B-1:0]   mac_data;
  logic [B-1:0]     mac_keep;
  logic             mac_last;
  logic             mac_valid;
  logic             mac_ack = 1'b1;
  logic             busy;
  logic [CW-1:0]    tx_cnt;

  arp_tx_engine #(.BYTES(B), .IFG_CYCLES(IFG), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .hw_addr_i           (hw_addr),
    .ip_addr_i           (ip_addr),
    .arp_req_pkt_i       (req_pkt),
    .arp_req_pkt_valid_i (req_valid),
    .arp_req_pkt_ack_o   (req_ack),
    .garp_req_i          (garp_req),
    .garp_ack_o          (garp_ack),
    .mac_data_o          (mac_data),
    .mac_keep_o          (mac_keep),
    .mac_last_o          (mac_last),
    .mac_valid_o         (mac_valid),
    .mac_ack_i           (mac_ack),
    .busy_o              (busy),
    .tx_cnt_o            (tx_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame as a byte list, then cut into beats.
  typedef struct {
    logic [8*B-1:0] data;
    logic [B-1:0]   keep;
    logic           last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] fbytes[$];

  function automatic void put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fbytes.push_back(v[8*i +: 8]);
  endfunction

  function automatic void push_frame(input logic [47:0] dst, input logic [47:0] src,
                                     input logic [15:0] op, input logic [47:0] smac,
                                     input logic [31:0] sip, input logic [47:0] tmac,
                                     input logic [31:0] tip);
    beat_t bt;
    fbytes.delete();
    put(dst, 6); put(src, 6); put(64'h0806, 2); put(64'h0001, 2); put(64'h0800, 2);
    put(64'd6, 1); put(64'd4, 1); put(op, 2); put(smac, 6); put(sip, 4);
    put(tmac, 6); put(tip, 4);
    while (fbytes.size() < FL) fbytes.push_back(8'h00);
    for (int b = 0; b < NB; b++) begin
      bt.data = '0;
      bt.keep = '0;
      for (int l = 0; l < B; l++) begin
        if (b * B + l < FL) begin
          bt.data[8*l +: 8] = fbytes[b*B + l];
          bt.keep[l]        = 1'b1;
        end
      end
      bt.last = (b == NB - 1);
      exp_q.push_back(bt);
    end
  endfunction

  // Monitor: models idle/send/gap phases at frame level and checks every cycle.
  int          phase = 0;  // 0 idle, 1 sending, 2 inter-frame gap
  int          gap_left = 0;
  int          mcnt = 0;
  int          beat_idx = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          gap_meas = 0;
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [63:0] prev_beat = '0;

  always @(negedge clk) begin
    logic  exp_arp, exp_garp;
    beat_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      phase      = 0;
      mcnt       = 0;
      beat_idx   = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      exp_arp  = (phase == 0) && req_valid;
      exp_garp = (phase == 0) && garp_req && !req_valid;
      chk("arp_ack", req_ack, exp_arp);
      chk("garp_ack", garp_ack, exp_garp);
      chk("busy", busy, phase != 0);
      chk("valid", mac_valid, phase == 1);
      chk("tx_cnt", tx_cnt, mcnt % (1 << CW));
      if (prev_stall && mac_valid) chk("stall_hold", {mac_data, mac_keep, mac_last}, prev_beat);
      if (mac_valid && !prev_valid) gap_meas = cyc - last_hs_cyc;
      case (phase)
        0: begin
          if (exp_arp) begin
            push_frame(req_pkt.src_mac, hw_addr, 16'h0002, hw_addr, ip_addr,
                       req_pkt.sender_mac, req_pkt.sender_ip);
            phase    = 1;
            beat_idx = 0;
          end else if (exp_garp) begin
            push_frame(48'hFFFF_FFFF_FFFF, hw_addr, 16'h0001, hw_addr, ip_addr, 48'h0, ip_addr);
            phase    = 1;
            beat_idx = 0;
          end
        end
        1: begin
          if (mac_valid && mac_ack) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL beat_unexpected: got %0h expected none", mac_data);
            end else begin
              e = exp_q.pop_front();
              chk("data", mac_data, e.data);
              chk("keep", mac_keep, e.keep);
              chk("last", mac_last, e.last);
              beat_idx++;
              if (e.last) begin
                mcnt++;
                last_hs_cyc = cyc;
                phase       = 2;
                gap_left    = IFG;
              end
            end
          end
        end
        default: begin
          gap_left--;
          if (gap_left == 0) phase = 0;
        end
      endcase
      prev_stall = mac_valid && !mac_ack;
      prev_beat  = {mac_data, mac_keep, mac_last};
      prev_valid = mac_valid;
    end
  end

  // MAC back-pressure.
  bit rand_ack = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mac_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  function automatic ether_arp_frame_t rand_pkt();
    ether_arp_frame_t p;
    p            = '0;
    p.dst_mac    = rand48();
    p.src_mac    = rand48();
    p.opcode     = 16'h0001;
    p.sender_mac = rand48();
    p.sender_ip  = $urandom();
    p.target_ip  = $urandom();
    return p;
  endfunction

  // Present a request, wait for its pop, then scramble the local addresses.
  task automatic issue_req(input ether_arp_frame_t p);
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    req_pkt   = p;
    req_valid = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (req_ack) seen = 1'b1;
    end
    chk("req_ack_seen", seen, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_pkt   = rand_pkt();
    hw_addr   = rand48();
    ip_addr   = $urandom();
  endtask

  task automatic issue_garp();
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    garp_req = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (garp_ack) seen = 1'b1;
    end
    chk("garp_ack_seen", seen, 1);
    @(posedge clk);
    #1;
    garp_req = 1'b0;
    hw_addr  = rand48();
    ip_addr  = $urandom();
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (phase == 0 && exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("idle_reached", done, 1);
  endtask

  initial begin
    ether_arp_frame_t p;
    bit               hit;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", mac_valid, 0);
    chk("rst_last", mac_last, 0);
    chk("rst_keep", mac_keep, 0);
    chk("rst_data", mac_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", tx_cnt, 0);
    chk("rst_acks", {req_ack, garp_ack}, 0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    hw_addr = 48'h0A_1B_2C_3D_4E_5F;
    ip_addr = 32'hC0A8_0001;

    // Directed reply.
    p            = rand_pkt();
    p.src_mac    = 48'h02_00_00_00_00_AA;
    p.sender_ip  = 32'h0A00_0005;
    issue_req(p);
    wait_idle();
    chk("cnt_after_first", tx_cnt, 1);

    // Both sources pending together: reply first, announcement after the gap.
    @(posedge clk);
    #1;
    garp_req  = 1'b1;
    req_pkt   = rand_pkt();
    req_valid = 1'b1;
    hit       = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (req_ack) hit = 1'b1;
    end
    chk("arb_reply_ack", hit, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hit       = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (garp_ack) hit = 1'b1;
    end
    chk("arb_garp_ack", hit, 1);
    @(posedge clk);
    #1;
    garp_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("arb_gap", gap_meas, IFG + 2);
    wait_idle();

    // Random traffic under 50% back-pressure; covers counter wrap.
    rand_ack = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 2) == 0) issue_garp();
      else issue_req(rand_pkt());
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    rand_ack = 1'b0;

    // Reset in the middle of a frame.
    issue_req(rand_pkt());
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (phase == 1 && beat_idx >= 5) hit = 1'b1;
    end
    chk("reach_beat5", hit, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("valid_after_rst", mac_valid, 0);
    chk("cnt_after_rst", tx_cnt, 0);
    repeat (4) begin
      @(negedge clk);
      chk("no_ack_after_rst", {req_ack, garp_ack, mac_valid}, 0);
    end
    issue_req(rand_pkt());
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
